// File: rtl/rv32_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32_pkg
// Description : RV32I base opcodes, immediate-format encoding and small
//               decode helpers shared by the decode/issue stage.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32_pkg;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // Immediate format carried by an opcode; R-type and unknown opcodes have none
  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_e;

  function automatic imm_type_e imm_type_of(input logic [6:0] opcode);
    imm_type_e t;
    case (opcode)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR,
      OPC_SYSTEM, OPC_MISC_MEM: t = IMM_I;
      OPC_STORE:                t = IMM_S;
      OPC_BRANCH:               t = IMM_B;
      OPC_LUI, OPC_AUIPC:       t = IMM_U;
      OPC_JAL:                  t = IMM_J;
      default:                  t = IMM_NONE;
    endcase
    return t;
  endfunction

  function automatic logic opcode_legal(input logic [6:0] opcode);
    logic ok;
    case (opcode)
      OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_AUIPC, OPC_STORE, OPC_OP,
      OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM: ok = 1'b1;
      default:                                            ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/imm_gen.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen
// Description : Combinational immediate extraction for all RV32I formats,
//               sign-extended from instr[31] to the datapath width.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_gen
  import rv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm
);

  logic [31:0] w_imm32;

  // Reassemble the scattered immediate fields by format; B/J keep bit0 = 0
  always_comb begin
    w_imm32 = '0;
    case (imm_type_of(instr[6:0]))
      IMM_I:   w_imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   w_imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   w_imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                          instr[11:8], 1'b0};
      IMM_U:   w_imm32 = {instr[31:12], 12'b0};
      IMM_J:   w_imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                          instr[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase
  end

  assign imm = XLEN'($signed(w_imm32));

endmodule
`default_nettype wire

// File: rtl/decode_issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_issue_stage
// Description : Decode/issue stage in front of the register file. Provides
//               the WB->ID bypass, load-use bubble insertion with IF stall,
//               branch flush / memory stall handling and the ID/EX registers.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_issue_stage
  import rv32_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid,
  input  logic [31:0]       if_instr,
  input  logic [XLEN-1:0]   if_pc,
  output logic              id_stall,
  output logic [REG_AW-1:0] rf_rs1,
  output logic [REG_AW-1:0] rf_rs2,
  input  logic [XLEN-1:0]   rf_rs1_data,
  input  logic [XLEN-1:0]   rf_rs2_data,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              ex_flush,
  input  logic              mem_stall,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs1_val,
  output logic [XLEN-1:0]   ex_rs2_val,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic [XLEN-1:0]   ex_imm,
  output logic [6:0]        ex_opcode,
  output logic [2:0]        ex_funct3,
  output logic              ex_funct7b5,
  output logic              ex_memread,
  output logic              ex_regwrite,
  output logic              ex_illegal,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic [6:0]        w_opcode;
  logic [REG_AW-1:0] w_rs1;
  logic [REG_AW-1:0] w_rs2;
  logic [REG_AW-1:0] w_rd;
  logic              w_uses_rs1;
  logic              w_uses_rs2;
  logic              w_legal;
  logic              w_writes_rd;
  logic              w_load_use;
  logic              w_issue;
  logic [XLEN-1:0]   w_imm;
  logic [XLEN-1:0]   w_rs1_val;
  logic [XLEN-1:0]   w_rs2_val;

  logic              r_ex_valid;
  logic [XLEN-1:0]   r_ex_pc;
  logic [XLEN-1:0]   r_ex_rs1_val;
  logic [XLEN-1:0]   r_ex_rs2_val;
  logic [REG_AW-1:0] r_ex_rs1;
  logic [REG_AW-1:0] r_ex_rs2;
  logic [REG_AW-1:0] r_ex_rd;
  logic [XLEN-1:0]   r_ex_imm;
  logic [6:0]        r_ex_opcode;
  logic [2:0]        r_ex_funct3;
  logic              r_ex_funct7b5;
  logic              r_ex_memread;
  logic              r_ex_regwrite;
  logic              r_ex_illegal;
  logic [CNT_W-1:0]  r_bubble_cnt;

  assign w_opcode = if_instr[6:0];
  assign w_rs1    = if_instr[15 +: REG_AW];
  assign w_rs2    = if_instr[20 +: REG_AW];
  assign w_rd     = if_instr[7 +: REG_AW];
  assign rf_rs1   = w_rs1;
  assign rf_rs2   = w_rs2;

  assign w_uses_rs1  = !((w_opcode == OPC_LUI) || (w_opcode == OPC_AUIPC) ||
                         (w_opcode == OPC_JAL));
  assign w_uses_rs2  = (w_opcode == OPC_OP) || (w_opcode == OPC_STORE) ||
                       (w_opcode == OPC_BRANCH);
  assign w_legal     = opcode_legal(w_opcode);
  assign w_writes_rd = w_legal && (w_rd != '0) &&
                       (w_opcode != OPC_STORE) && (w_opcode != OPC_BRANCH);

  // A load still in EX cannot forward to us yet, so the consumer waits a cycle
  assign w_load_use = if_valid && r_ex_valid && r_ex_memread && (r_ex_rd != '0) &&
                      ((w_uses_rs1 && (r_ex_rd == w_rs1)) ||
                       (w_uses_rs2 && (r_ex_rd == w_rs2)));

  // Flush beats the hazard: IF must be free to fetch the redirect target
  assign id_stall = mem_stall || (!ex_flush && w_load_use);
  assign w_issue  = if_valid && !ex_flush && !w_load_use;

  // The register file has no write-before-read path, so WB is bypassed here
  assign w_rs1_val = (w_rs1 == '0) ? '0 :
                     (wb_regwrite && (wb_rd == w_rs1)) ? wb_data : rf_rs1_data;
  assign w_rs2_val = (w_rs2 == '0) ? '0 :
                     (wb_regwrite && (wb_rd == w_rs2)) ? wb_data : rf_rs2_data;

  imm_gen #(
    .XLEN (XLEN)
  ) u_imm_gen (
    .instr (if_instr),
    .imm   (w_imm)
  );

  // ID/EX bundle: hold on mem_stall, otherwise capture with valid gated by hazards
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid    <= 1'b0;
      r_ex_pc       <= '0;
      r_ex_rs1_val  <= '0;
      r_ex_rs2_val  <= '0;
      r_ex_rs1      <= '0;
      r_ex_rs2      <= '0;
      r_ex_rd       <= '0;
      r_ex_imm      <= '0;
      r_ex_opcode   <= '0;
      r_ex_funct3   <= '0;
      r_ex_funct7b5 <= 1'b0;
      r_ex_memread  <= 1'b0;
      r_ex_regwrite <= 1'b0;
      r_ex_illegal  <= 1'b0;
    end else if (!mem_stall) begin
      r_ex_valid    <= w_issue;
      r_ex_pc       <= if_pc;
      r_ex_rs1_val  <= w_rs1_val;
      r_ex_rs2_val  <= w_rs2_val;
      r_ex_rs1      <= w_rs1;
      r_ex_rs2      <= w_rs2;
      r_ex_rd       <= w_rd;
      r_ex_imm      <= w_imm;
      r_ex_opcode   <= w_opcode;
      r_ex_funct3   <= if_instr[14:12];
      r_ex_funct7b5 <= if_instr[30];
      r_ex_memread  <= w_issue && (w_opcode == OPC_LOAD);
      r_ex_regwrite <= w_issue && w_writes_rd;
      r_ex_illegal  <= !w_legal;
    end
  end

  // Count inserted load-use bubbles, sticking at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bubble_cnt <= '0;
    end else if (!mem_stall && !ex_flush && w_load_use &&
                 (r_bubble_cnt != {CNT_W{1'b1}})) begin
      r_bubble_cnt <= r_bubble_cnt + 1'b1;
    end
  end

  assign ex_valid    = r_ex_valid;
  assign ex_pc       = r_ex_pc;
  assign ex_rs1_val  = r_ex_rs1_val;
  assign ex_rs2_val  = r_ex_rs2_val;
  assign ex_rs1      = r_ex_rs1;
  assign ex_rs2      = r_ex_rs2;
  assign ex_rd       = r_ex_rd;
  assign ex_imm      = r_ex_imm;
  assign ex_opcode   = r_ex_opcode;
  assign ex_funct3   = r_ex_funct3;
  assign ex_funct7b5 = r_ex_funct7b5;
  assign ex_memread  = r_ex_memread;
  assign ex_regwrite = r_ex_regwrite;
  assign ex_illegal  = r_ex_illegal;
  assign bubble_cnt  = r_bubble_cnt;

endmodule
`default_nettype wire

// File: tb/tb_decode_issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_issue_stage
// Description : Self-checking bench for decode_issue_stage: directed corner
//               sequences, a decode vector table and randomized traffic
//               against an ISA-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_issue_stage;

  // RV32I major opcodes, written out from the ISA manual
  localparam logic [6:0] T_LOAD   = 7'h03;
  localparam logic [6:0] T_MISC   = 7'h0F;
  localparam logic [6:0] T_IMM    = 7'h13;
  localparam logic [6:0] T_AUIPC  = 7'h17;
  localparam logic [6:0] T_STORE  = 7'h23;
  localparam logic [6:0] T_OP     = 7'h33;
  localparam logic [6:0] T_LUI    = 7'h37;
  localparam logic [6:0] T_BRANCH = 7'h63;
  localparam logic [6:0] T_JALR   = 7'h67;
  localparam logic [6:0] T_JAL    = 7'h6F;
  localparam logic [6:0] T_SYSTEM = 7'h73;

  localparam logic [31:0] ADD_X3_X1_X2 = 32'h002081B3;
  localparam logic [31:0] ADD_X6_X5_X1 = 32'h00128333;
  localparam logic [31:0] LW_X5_0_X1   = 32'h0000A283;
  localparam logic [31:0] LUI_X5       = 32'h123452B7;
  localparam logic [31:0] ADDI_X1_M1   = 32'hFFF00093;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_instr, if_pc;
  logic        id_stall;
  logic [4:0]  rf_rs1, rf_rs2;
  logic [31:0] rf_rs1_data, rf_rs2_data;
  logic        wb_regwrite;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_flush, mem_stall;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic        ex_funct7b5, ex_memread, ex_regwrite, ex_illegal;
  logic [15:0] bubble_cnt;

  logic        s_id_stall;
  logic [4:0]  s_rf_rs1, s_rf_rs2;
  logic        s_ex_valid;
  logic [31:0] s_ex_pc, s_ex_rs1_val, s_ex_rs2_val, s_ex_imm;
  logic [4:0]  s_ex_rs1, s_ex_rs2, s_ex_rd;
  logic [6:0]  s_ex_opcode;
  logic [2:0]  s_ex_funct3;
  logic        s_ex_funct7b5, s_ex_memread, s_ex_regwrite, s_ex_illegal;
  logic [1:0]  s_bubble_cnt;

  always #5 clk = ~clk;

  decode_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_stall(id_stall), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_flush(ex_flush), .mem_stall(mem_stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_imm(ex_imm), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3),
    .ex_funct7b5(ex_funct7b5), .ex_memread(ex_memread), .ex_regwrite(ex_regwrite),
    .ex_illegal(ex_illegal), .bubble_cnt(bubble_cnt)
  );

  decode_issue_stage #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_stall(s_id_stall), .rf_rs1(s_rf_rs1), .rf_rs2(s_rf_rs2),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_flush(ex_flush), .mem_stall(mem_stall), .ex_valid(s_ex_valid), .ex_pc(s_ex_pc),
    .ex_rs1_val(s_ex_rs1_val), .ex_rs2_val(s_ex_rs2_val), .ex_rs1(s_ex_rs1),
    .ex_rs2(s_ex_rs2), .ex_rd(s_ex_rd), .ex_imm(s_ex_imm), .ex_opcode(s_ex_opcode),
    .ex_funct3(s_ex_funct3), .ex_funct7b5(s_ex_funct7b5), .ex_memread(s_ex_memread),
    .ex_regwrite(s_ex_regwrite), .ex_illegal(s_ex_illegal), .bubble_cnt(s_bubble_cnt)
  );

  // Reference view of the instruction currently sitting in EX
  typedef struct {
    logic        valid;
    logic [31:0] pc, rs1v, rs2v, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        f7b5, memread, regwrite, illegal;
  } ex_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    logic        chk_imm;
    logic        illegal;
    logic        regwrite;
    logic        memread;
  } vec_t;

  ex_t         m;
  int unsigned m_cnt;
  int          checks = 0;
  int          errors = 0;
  logic        seen_stall;
  logic [31:0] pc_hold;
  vec_t        tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic logic is_legal(input logic [6:0] op);
    return op inside {T_LOAD, T_MISC, T_IMM, T_AUIPC, T_STORE, T_OP, T_LUI,
                      T_BRANCH, T_JALR, T_JAL, T_SYSTEM};
  endfunction

  function automatic logic has_imm(input logic [6:0] op);
    return op inside {T_LOAD, T_IMM, T_JALR, T_STORE, T_BRANCH, T_LUI, T_AUIPC, T_JAL};
  endfunction

  // Immediates rebuilt arithmetically: arithmetic shifts of the signed word
  function automatic logic [31:0] ref_imm(input logic [31:0] ins);
    int s;
    int v;
    s = int'(ins);
    case (ins[6:0])
      T_STORE:        v = ((s >>> 25) << 5) | int'(32'(ins[11:7]));
      T_BRANCH:       v = ((s >>> 31) << 12) | int'(32'(ins[7]) << 11) |
                          int'(32'(ins[30:25]) << 5) | int'(32'(ins[11:8]) << 1);
      T_LUI, T_AUIPC: v = s & int'(32'hFFFF_F000);
      T_JAL:          v = ((s >>> 31) << 20) | int'(32'(ins[19:12]) << 12) |
                          int'(32'(ins[20]) << 11) | int'(32'(ins[30:21]) << 1);
      default:        v = s >>> 20;
    endcase
    return 32'(v);
  endfunction

  function automatic logic [31:0] opnd(input logic [4:0] s, input logic [31:0] rfd);
    if (s == 5'd0) return 32'd0;
    if (wb_regwrite && wb_rd == s) return wb_data;
    return rfd;
  endfunction

  task automatic model_reset();
    m = '{default: '0};
    m_cnt = 0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, ex_valid, 0);
    chk({tag, "_pc"}, ex_pc, 0);
    chk({tag, "_rs1v"}, ex_rs1_val, 0);
    chk({tag, "_rs2v"}, ex_rs2_val, 0);
    chk({tag, "_idx"}, {ex_rs1, ex_rs2, ex_rd}, 0);
    chk({tag, "_imm"}, ex_imm, 0);
    chk({tag, "_dec"}, {ex_opcode, ex_funct3, ex_funct7b5}, 0);
    chk({tag, "_flags"}, {ex_memread, ex_regwrite, ex_illegal}, 0);
    chk({tag, "_cnt"}, bubble_cnt, 0);
    chk({tag, "_cnt_sat"}, s_bubble_cnt, 0);
  endtask

  task automatic check_regs();
    chk("ex_valid", ex_valid, m.valid);
    chk("ex_regwrite", ex_regwrite, m.regwrite);
    chk("ex_memread", ex_memread, m.memread);
    chk("bubble_cnt", bubble_cnt, m_cnt);
    chk("bubble_cnt_sat", s_bubble_cnt, (m_cnt > 3) ? 3 : m_cnt);
    if (m.valid) begin
      chk("ex_pc", ex_pc, m.pc);
      chk("ex_rs1_val", ex_rs1_val, m.rs1v);
      chk("ex_rs2_val", ex_rs2_val, m.rs2v);
      chk("ex_regidx", {ex_rs1, ex_rs2, ex_rd}, {m.rs1, m.rs2, m.rd});
      chk("ex_decode", {ex_opcode, ex_funct3, ex_funct7b5}, {m.opc, m.f3, m.f7b5});
      chk("ex_illegal", ex_illegal, m.illegal);
      if (has_imm(m.opc)) chk("ex_imm", ex_imm, m.imm);
    end
  endtask

  // One clock of stimulus: drive at negedge, check comb outputs, predict, check after edge
  task automatic step(input logic v, input logic [31:0] ins, input logic fl, input logic ms);
    ex_t         n;
    int unsigned n_cnt;
    logic        lu, u1, u2;
    logic [4:0]  rs1, rs2, rd;
    logic [6:0]  op;
    @(negedge clk);
    if_valid  = v;
    if_instr  = ins;
    if_pc     = $urandom;
    ex_flush  = fl;
    mem_stall = ms;
    #1;
    op  = ins[6:0];
    rs1 = ins[19:15];
    rs2 = ins[24:20];
    rd  = ins[11:7];
    u1  = !(op inside {T_LUI, T_AUIPC, T_JAL});
    u2  = op inside {T_OP, T_STORE, T_BRANCH};
    lu  = v && m.valid && m.memread && m.rd != 0 &&
          ((u1 && m.rd == rs1) || (u2 && m.rd == rs2));
    chk("id_stall", id_stall, ms || (!fl && lu));
    chk("rf_rs1", rf_rs1, rs1);
    chk("rf_rs2", rf_rs2, rs2);
    seen_stall = id_stall;
    n     = m;
    n_cnt = m_cnt;
    if (!ms) begin
      if (fl || lu) begin
        n.valid    = 1'b0;
        n.regwrite = 1'b0;
        n.memread  = 1'b0;
        if (!fl && n_cnt < 65535) n_cnt++;
      end else begin
        n.valid    = v;
        n.pc       = if_pc;
        n.rs1v     = opnd(rs1, rf_rs1_data);
        n.rs2v     = opnd(rs2, rf_rs2_data);
        n.rs1      = rs1;
        n.rs2      = rs2;
        n.rd       = rd;
        n.imm      = ref_imm(ins);
        n.opc      = op;
        n.f3       = ins[14:12];
        n.f7b5     = ins[30];
        n.illegal  = !is_legal(op);
        n.memread  = v && op == T_LOAD;
        n.regwrite = v && is_legal(op) && rd != 0 && op != T_STORE && op != T_BRANCH;
      end
    end
    @(posedge clk);
    #1;
    m     = n;
    m_cnt = n_cnt;
    check_regs();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [6:0] ops[13];
    logic [31:0] ins;
    ops = '{T_LOAD, T_LOAD, T_MISC, T_IMM, T_AUIPC, T_STORE, T_OP, T_LUI,
            T_BRANCH, T_JALR, T_JAL, T_SYSTEM, 7'h7F};

    //            instr          imm            chk ill rw mr
    tbl[0]  = '{32'h002081B3, 32'h0000_0000, 0, 0, 1, 0}; // ADD  x3,x1,x2
    tbl[1]  = '{32'h0000A283, 32'h0000_0000, 1, 0, 1, 1}; // LW   x5,0(x1)
    tbl[2]  = '{32'h123452B7, 32'h1234_5000, 1, 0, 1, 0}; // LUI  x5,0x12345
    tbl[3]  = '{32'hFE208EE3, 32'hFFFF_FFFC, 1, 0, 0, 0}; // BEQ  x1,x2,-4
    tbl[4]  = '{32'h0020A423, 32'h0000_0008, 1, 0, 0, 0}; // SW   x2,8(x1)
    tbl[5]  = '{32'h000001FF, 32'h0000_0000, 0, 1, 0, 0}; // unknown opcode
    tbl[6]  = '{32'h001000EF, 32'h0000_0800, 1, 0, 1, 0}; // JAL  x1,+2048
    tbl[7]  = '{32'hFFF00093, 32'hFFFF_FFFF, 1, 0, 1, 0}; // ADDI x1,x0,-1
    tbl[8]  = '{32'hFFFFF117, 32'hFFFF_F000, 1, 0, 1, 0}; // AUIPC x2,0xFFFFF
    tbl[9]  = '{32'hFFFFF06F, 32'hFFFF_FFFE, 1, 0, 0, 0}; // JAL  x0,-2
    tbl[10] = '{32'hFF0100E7, 32'hFFFF_FFF0, 1, 0, 1, 0}; // JALR x1,-16(x2)
    tbl[11] = '{32'h0020E033, 32'h0000_0000, 0, 0, 0, 0}; // OR   x0,x1,x2

    rst_n = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0;
    rf_rs1_data = '0; rf_rs2_data = '0; wb_regwrite = 1'b0; wb_rd = '0; wb_data = '0;
    ex_flush = 1'b0; mem_stall = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // WB bypass wins over stale register file data
    rf_rs1_data = 32'd5; rf_rs2_data = 32'd7;
    wb_regwrite = 1'b1; wb_rd = 5'd1; wb_data = 32'd9;
    step(1'b1, ADD_X3_X1_X2, 1'b0, 1'b0);
    chk("bypass_rs1", ex_rs1_val, 32'd9);
    chk("bypass_rs2", ex_rs2_val, 32'd7);

    // A WB write aimed at x0 never reaches an x0 source
    wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF; rf_rs1_data = 32'h1234;
    step(1'b1, ADDI_X1_M1, 1'b0, 1'b0);
    chk("x0_guard", ex_rs1_val, 32'd0);
    wb_regwrite = 1'b0;

    // Load-use: exactly one bubble, then the consumer issues
    step(1'b1, LW_X5_0_X1, 1'b0, 1'b0);
    step(1'b1, ADD_X6_X5_X1, 1'b0, 1'b0);
    chk("lu_stall", seen_stall, 1);
    chk("lu_bubble", ex_valid, 0);
    chk("lu_cnt", bubble_cnt, 1);
    step(1'b1, ADD_X6_X5_X1, 1'b0, 1'b0);
    chk("lu_release", seen_stall, 0);
    chk("lu_issue", ex_valid, 1);
    chk("lu_rd", ex_rd, 6);

    // LUI does not read rs1, so no hazard against the load
    step(1'b1, LW_X5_0_X1, 1'b0, 1'b0);
    step(1'b1, LUI_X5, 1'b0, 1'b0);
    chk("lui_nostall", seen_stall, 0);
    chk("lui_valid", ex_valid, 1);
    chk("lui_imm", ex_imm, 32'h1234_5000);

    // Flush together with load-use: flush wins, counter untouched
    step(1'b1, LW_X5_0_X1, 1'b0, 1'b0);
    step(1'b1, ADD_X6_X5_X1, 1'b1, 1'b0);
    chk("prio_stall", seen_stall, 0);
    chk("prio_valid", ex_valid, 0);
    chk("prio_cnt", bubble_cnt, 1);

    // Memory stall freezes the bundle for three cycles
    step(1'b1, ADDI_X1_M1, 1'b0, 1'b0);
    pc_hold = if_pc;
    for (int k = 0; k < 3; k++) begin
      step(1'b1, ADD_X6_X5_X1, 1'b0, 1'b1);
      chk("mst_stall", seen_stall, 1);
      chk("mst_valid", ex_valid, 1);
      chk("mst_imm", ex_imm, 32'hFFFF_FFFF);
      chk("mst_rd", ex_rd, 1);
      chk("mst_pc", ex_pc, pc_hold);
    end

    // Decode table
    for (int i = 0; i < 12; i++) begin
      step(1'b1, tbl[i].instr, 1'b0, 1'b0);
      chk("tbl_valid", ex_valid, 1);
      chk("tbl_illegal", ex_illegal, tbl[i].illegal);
      chk("tbl_regwrite", ex_regwrite, tbl[i].regwrite);
      chk("tbl_memread", ex_memread, tbl[i].memread);
      if (tbl[i].chk_imm) chk("tbl_imm", ex_imm, tbl[i].imm);
    end

    // Asynchronous reset in mid-run, away from any clock edge
    chk("prereset_valid", ex_valid, 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Four load-use events: 16-bit counter reads 4, 2-bit counter sticks at 3
    for (int k = 0; k < 4; k++) begin
      step(1'b1, LW_X5_0_X1, 1'b0, 1'b0);
      step(1'b1, ADD_X6_X5_X1, 1'b0, 1'b0);
      step(1'b1, ADD_X6_X5_X1, 1'b0, 1'b0);
    end
    chk("sat_cnt", s_bubble_cnt, 3);
    chk("wide_cnt", bubble_cnt, 4);

    // Randomized traffic against the reference model
    for (int k = 0; k < 800; k++) begin
      ins = $urandom;
      ins[6:0]   = ops[$urandom_range(0, 12)];
      ins[11:7]  = 5'($urandom_range(0, 7));
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      rf_rs1_data = $urandom;
      rf_rs2_data = $urandom;
      wb_regwrite = 1'($urandom_range(0, 1));
      wb_rd       = 5'($urandom_range(0, 7));
      wb_data     = $urandom;
      step($urandom_range(0, 7) != 0, ins, $urandom_range(0, 9) == 0,
           $urandom_range(0, 6) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
